// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment scan driver with a double-buffered, frame-synchronous digit bank.
// Optional blink support is built when SSD_BLINK_EN is defined.
module ssd_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned PRESCALE     = 131072,
    parameter int unsigned BLINK_FRAMES = 48
) (
    input  logic                    ClkPort,
    input  logic                    Reset,
    input  logic [5*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    load,
    output logic                    pending,
    output logic                    frame_done,
    output logic [NUM_DIGITS-1:0]   An,
    output logic [7:0]              Cath
);

    localparam int unsigned PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DW    = 5 * NUM_DIGITS;
    localparam logic [DW-1:0] BLANK_BANK = {NUM_DIGITS{5'd16}};

    logic [PS_W-1:0]       pre;
    logic [IDX_W-1:0]      idx;
    logic                  slot_end;
    logic                  frame_end;

    logic [DW-1:0]         sh_data;
    logic [NUM_DIGITS-1:0] sh_en;
    logic [NUM_DIGITS-1:0] sh_dp;
    logic [DW-1:0]         act_data;
    logic [NUM_DIGITS-1:0] act_en;
    logic [NUM_DIGITS-1:0] act_dp;

    logic [4:0]            cur_code;
    logic                  cur_en;
    logic                  cur_dp;
    logic                  hide;
    logic [NUM_DIGITS-1:0] an_nxt;

    // Active-low {a,b,c,d,e,f,g} pattern for each glyph code.
    function automatic logic [6:0] glyph(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'd0:    seg = 7'b0000001;
            5'd1:    seg = 7'b1001111;
            5'd2:    seg = 7'b0010010;
            5'd3:    seg = 7'b0000110;
            5'd4:    seg = 7'b1001100;
            5'd5:    seg = 7'b0100100;
            5'd6:    seg = 7'b0100000;
            5'd7:    seg = 7'b0001111;
            5'd8:    seg = 7'b0000000;
            5'd9:    seg = 7'b0000100;
            5'd10:   seg = 7'b0001000;
            5'd11:   seg = 7'b1100000;
            5'd12:   seg = 7'b0110001;
            5'd13:   seg = 7'b1000010;
            5'd14:   seg = 7'b0110000;
            5'd15:   seg = 7'b0111000;
            5'd17:   seg = 7'b0111000;
            5'd18:   seg = 7'b1110001;
            5'd19:   seg = 7'b1111010;
            5'd20:   seg = 7'b0110000;
            5'd21:   seg = 7'b1111110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    assign slot_end  = (pre == PS_W'(PRESCALE - 1));
    assign frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

    // Slot prescaler and digit index; the index wrap marks the frame boundary.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            pre <= '0;
            idx <= '0;
        end else if (slot_end) begin
            pre <= '0;
            idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Shadow/active banks: a commit always takes the pre-edge shadow, so a same-edge load stays pending.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            sh_data    <= BLANK_BANK;
            sh_en      <= '0;
            sh_dp      <= '0;
            act_data   <= BLANK_BANK;
            act_en     <= '0;
            act_dp     <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end && pending;
            if (frame_end && pending) begin
                act_data <= sh_data;
                act_en   <= sh_en;
                act_dp   <= sh_dp;
                pending  <= 1'b0;
            end
            if (load) begin
                sh_data <= digit_data;
                sh_en   <= digit_en;
                sh_dp   <= dp_in;
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        cur_code = act_data[4:0];
        cur_en   = act_en[0];
        cur_dp   = act_dp[0];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_code = act_data[5*i +: 5];
                cur_en   = act_en[i];
                cur_dp   = act_dp[i];
            end
        end
    end

`ifdef SSD_BLINK_EN
    localparam int unsigned BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BF_W-1:0]       frame_cnt;
    logic                  blink_phase;
    logic [NUM_DIGITS-1:0] sh_blink;
    logic [NUM_DIGITS-1:0] act_blink;
    logic                  cur_blink;

    // Blink phase flips every BLINK_FRAMES frame boundaries, independent of commits.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == BF_W'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            sh_blink  <= '0;
            act_blink <= '0;
        end else begin
            if (frame_end && pending) begin
                act_blink <= sh_blink;
            end
            if (load) begin
                sh_blink <= blink_mask;
            end
        end
    end

    always_comb begin
        cur_blink = act_blink[0];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_blink = act_blink[i];
            end
        end
    end

    assign hide = blink_phase && cur_blink;
`else
    logic unused_blink;
    assign unused_blink = ^{blink_mask, 32'(BLINK_FRAMES)};
    assign hide         = 1'b0;
`endif

    always_comb begin
        an_nxt = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((idx == IDX_W'(i)) && cur_en && !hide) begin
                an_nxt[i] = 1'b0;
            end
        end
    end

    // Registered pin drivers, one cycle behind idx/active.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            An   <= '1;
            Cath <= 8'hFF;
        end else begin
            An   <= an_nxt;
            Cath <= {glyph(cur_code), ~cur_dp};
        end
    end

endmodule
